// File: rtl/azadi_wb_ctrl.sv
// Wishbone control slave for the Azadi SoC: UART divisor, stretched/soft SoC reset, debounced prog input.
// Optional programming-event interrupt is enabled by defining AZADI_WB_CTRL_IRQ_EN.
module azadi_wb_ctrl #(
   parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
   parameter logic [15:0] DEFAULT_CPB     = 16'd868,
   parameter int          RST_HOLD        = 16,
   parameter int          DEBOUNCE_CYCLES = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        prog_pad_i,
   output logic [15:0] clks_per_bit_o,
   output logic        soc_rst_no,
   output logic        soc_prog_o,
   output logic        irq_o
);

   typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} state_e;

   localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);
   localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic        soc_rst_n_q, soc_rst_n_d;
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] cpb_q, cpb_d;
   logic [31:0] scratch_q, scratch_d;
   logic        ovr_q, ovr_d, val_q, val_d;
   logic [1:0]  sync_q, sync_d;
   logic        filt_q, filt_d;
   logic [7:0]  deb_cnt_q, deb_cnt_d;
   logic        prog_q, prog_d;
   logic        irq_pend_q, irq_pend_d;

   logic        in_win, accept, wr_en, soft_rst, irq_clr;
   logic        unused_adr;

   assign in_win     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign accept     = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign wr_en      = accept & wbs_we_i & in_win;
   assign unused_adr = ^wbs_adr_i[1:0];

   // Bus side: writes land on the accept edge, which is also the edge that raises ack.
   always_comb begin
      cpb_d     = cpb_q;
      scratch_d = scratch_q;
      ovr_d     = ovr_q;
      val_d     = val_q;
      soft_rst  = 1'b0;
      irq_clr   = 1'b0;
      ack_d     = accept;
      rdata_d   = '0;
      if (wr_en) begin
         case (wbs_adr_i[3:2])
            2'd0: if (wbs_sel_i[0]) begin
               soft_rst = wbs_dat_i[0];
               ovr_d    = wbs_dat_i[1];
               val_d    = wbs_dat_i[2];
            end
            2'd1: begin
               if (wbs_sel_i[0]) cpb_d[7:0]  = wbs_dat_i[7:0];
               if (wbs_sel_i[1]) cpb_d[15:8] = wbs_dat_i[15:8];
            end
            2'd2: irq_clr = wbs_sel_i[0] & wbs_dat_i[3];
            default: begin
               for (int b = 0; b < 4; b++) begin
                  if (wbs_sel_i[b]) scratch_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
               end
            end
         endcase
      end
      if (accept && !wbs_we_i && in_win) begin
         case (wbs_adr_i[3:2])
            2'd0:    rdata_d = {29'd0, val_q, ovr_q, 1'b0};
            2'd1:    rdata_d = {16'd0, cpb_q};
            2'd2:    rdata_d = {28'd0, irq_pend_q, sync_q[1], filt_q, ~soc_rst_n_q};
            default: rdata_d = scratch_q;
         endcase
      end
   end

   // Reset sequencer; soc_rst_no follows the state one cycle later.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      soc_rst_n_d = (state_q == ST_RUN);
      case (state_q)
         ST_HOLD: begin
            if (soft_rst) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            if (soft_rst) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end
         end
      endcase
   end

   always_comb begin
      sync_d    = {sync_q[0], prog_pad_i};
      filt_d    = filt_q;
      deb_cnt_d = deb_cnt_q;
      if (sync_q[1] == filt_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         filt_d    = sync_q[1];
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + 8'd1;
      end
      prog_d = ovr_q ? val_q : filt_q;
`ifdef AZADI_WB_CTRL_IRQ_EN
      // A new rising edge wins over a simultaneous clear.
      irq_pend_d = (filt_d & ~filt_q) | (irq_pend_q & ~irq_clr);
`else
      irq_pend_d = 1'b0;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_HOLD;
         hold_cnt_q  <= '0;
         soc_rst_n_q <= 1'b0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         cpb_q       <= DEFAULT_CPB;
         scratch_q   <= '0;
         ovr_q       <= 1'b0;
         val_q       <= 1'b0;
         sync_q      <= '0;
         filt_q      <= 1'b0;
         deb_cnt_q   <= '0;
         prog_q      <= 1'b0;
         irq_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         soc_rst_n_q <= soc_rst_n_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         cpb_q       <= cpb_d;
         scratch_q   <= scratch_d;
         ovr_q       <= ovr_d;
         val_q       <= val_d;
         sync_q      <= sync_d;
         filt_q      <= filt_d;
         deb_cnt_q   <= deb_cnt_d;
         prog_q      <= prog_d;
         irq_pend_q  <= irq_pend_d;
      end
   end

   assign wbs_ack_o      = ack_q;
   assign wbs_dat_o      = rdata_q;
   assign clks_per_bit_o = cpb_q;
   assign soc_rst_no     = soc_rst_n_q;
   assign soc_prog_o     = prog_q;
`ifdef AZADI_WB_CTRL_IRQ_EN
   assign irq_o = irq_pend_q;
`else
   logic unused_irq;
   assign unused_irq = irq_clr;
   assign irq_o      = 1'b0;
`endif

endmodule
